atm_frame_sequencer: RTL and testbench

//   Parametrised successor channel sequencer for the ATM mux.

---
 rtl/atm_frame_sequencer_if.sv | 31 +++
 rtl/atm_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_atm_frame_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/atm_frame_sequencer_if.sv
// atm_frame_sequencer_if: control inputs and mux/data-path outputs of the ATM frame sequencer
interface atm_frame_sequencer_if #(
    parameter int NCH  = 8,
    parameter int CHW  = $clog2(NCH),
    parameter int OSRW = 4,
    parameter int FCW  = 8
);
    logic            ENSAMP_sync;
    logic [NCH-1:0]  CHEN_sync;
    logic [OSRW-1:0] OSR_sync;
    logic            ENLOWPWR_sync;
    logic            ONESHOT_sync;
    logic [NCH-1:0]  ATMCHSEL;
    logic [NCH-1:0]  ATMCHSEL_DATA;
    logic [CHW-1:0]  CHIDX_DATA;
    logic [NCH-1:0]  CHSEL;
    logic            LASTWORD;
    logic            FRAME_DONE;
    logic [FCW-1:0]  FRAME_CNT;
    logic            BUSY;

    modport master (
        output ENSAMP_sync, CHEN_sync, OSR_sync, ENLOWPWR_sync, ONESHOT_sync,
        input  ATMCHSEL, ATMCHSEL_DATA, CHIDX_DATA, CHSEL, LASTWORD, FRAME_DONE, FRAME_CNT, BUSY
    );

    modport slave (
        input  ENSAMP_sync, CHEN_sync, OSR_sync, ENLOWPWR_sync, ONESHOT_sync,
        output ATMCHSEL, ATMCHSEL_DATA, CHIDX_DATA, CHSEL, LASTWORD, FRAME_DONE, FRAME_CNT, BUSY
    );
endinterface

// File: rtl/atm_frame_sequencer.sv
// atm_frame_sequencer: OSR-timed circular channel sequencer with per-frame config latch and DONE-aligned data flags
module atm_frame_sequencer #(
    parameter int NCH  = 8,
    parameter int CHW  = $clog2(NCH),
    parameter int OSRW = 4,
    parameter int FCW  = 8
) (
    input logic SAMPLE_CLK,
    input logic NRST_sync,
    atm_frame_sequencer_if.slave bus
);
    localparam int CW = OSRW + 2;

    typedef enum logic [1:0] {IDLE, CONVERT, HALT} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  chen_l_q, chen_l_d;
    logic [OSRW-1:0] osr_l_q, osr_l_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  sel_q, sel_d;
    logic [NCH-1:0]  sel_data_q, sel_data_d;
    logic [CHW-1:0]  chidx_q, chidx_d;
    logic            last_q, last_d;
    logic            fdone_q, fdone_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;
    logic [CW-1:0]   term;
    logic [NCH-1:0]  above, next_ch, new_low;
    logic            at_term, frame_end, is_last;

    function automatic logic [CHW-1:0] onehot_idx(input logic [NCH-1:0] v);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++)
            if (v[i]) r = r | CHW'(i);
        return r;
    endfunction

    // Conversion timing and channel search: term = 4*osr+1 (len 4*osr+2), enabled channels above the current one
    always_comb begin
        term      = (osr_l_q == '0) ? '0 : {osr_l_q, 2'b01};
        above     = chen_l_q & ~(sel_q | (sel_q - NCH'(1)));
        next_ch   = above & (~above + NCH'(1));
        new_low   = bus.CHEN_sync & (~bus.CHEN_sync + NCH'(1));
        is_last   = (sel_q != '0) && (above == '0);
        at_term   = (state_q == CONVERT) && (cnt_q == term);
        frame_end = at_term && (above == '0);
    end

    // Next-state, channel switching and DONE-aligned pipeline; ENSAMP low overrides everything except the frame count
    always_comb begin
        state_d    = state_q;
        chen_l_d   = chen_l_q;
        osr_l_d    = osr_l_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        sel_data_d = sel_q;
        chidx_d    = onehot_idx(sel_q);
        last_d     = is_last;
        fdone_d    = frame_end;
        fcnt_d     = fcnt_q + FCW'(frame_end);
        case (state_q)
            IDLE: begin
                if (bus.ENSAMP_sync && bus.CHEN_sync != '0) begin
                    chen_l_d = bus.CHEN_sync;
                    osr_l_d  = bus.OSR_sync;
                    sel_d    = new_low;
                    cnt_d    = '0;
                    state_d  = CONVERT;
                end
            end
            CONVERT: begin
                cnt_d = cnt_q + CW'(1);
                if (at_term) begin
                    cnt_d = '0;
                    if (above != '0) begin
                        sel_d = next_ch;
                    end else if (bus.ONESHOT_sync) begin
                        sel_d   = '0;
                        state_d = HALT;
                    end else begin
                        chen_l_d = bus.CHEN_sync;
                        osr_l_d  = bus.OSR_sync;
                        sel_d    = new_low;
                        state_d  = (bus.CHEN_sync == '0) ? IDLE : CONVERT;
                    end
                end
            end
            HALT: sel_d = '0;
            default: state_d = IDLE;
        endcase
        if (!bus.ENSAMP_sync) begin
            state_d    = IDLE;
            sel_d      = '0;
            sel_data_d = '0;
            chidx_d    = '0;
            last_d     = 1'b0;
            fdone_d    = 1'b0;
            cnt_d      = '0;
            fcnt_d     = fcnt_q;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
        if (!NRST_sync) begin
            state_q    <= IDLE;
            chen_l_q   <= '0;
            osr_l_q    <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            sel_data_q <= '0;
            chidx_q    <= '0;
            last_q     <= 1'b0;
            fdone_q    <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            chen_l_q   <= chen_l_d;
            osr_l_q    <= osr_l_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            sel_data_q <= sel_data_d;
            chidx_q    <= chidx_d;
            last_q     <= last_d;
            fdone_q    <= fdone_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign bus.ATMCHSEL      = sel_q;
    assign bus.ATMCHSEL_DATA = sel_data_q;
    assign bus.CHIDX_DATA    = chidx_q;
    assign bus.LASTWORD      = last_q;
    assign bus.FRAME_DONE    = fdone_q;
    assign bus.FRAME_CNT     = fcnt_q;
    assign bus.BUSY          = (state_q == CONVERT);
    assign bus.CHSEL         = bus.ENLOWPWR_sync ? sel_q : bus.CHEN_sync;
endmodule

// File: tb/tb_atm_frame_sequencer.sv
// tb_atm_frame_sequencer: directed and random stimulus against a countdown-based frame model
module tb_atm_frame_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    // model state: mode 0 idle / 1 converting / 2 halted, cur = -1 when no channel selected
    int m_mode, m_cur, m_rem, m_chen, m_osr, m_fcnt;
    int e_data, e_idx, e_last, e_fd;

    atm_frame_sequencer_if #(.NCH(8), .OSRW(4), .FCW(8)) bus ();

    atm_frame_sequencer #(.NCH(8), .OSRW(4), .FCW(8)) dut (
        .SAMPLE_CLK(clk),
        .NRST_sync (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int clen(input int o);
        return (o == 0) ? 1 : 4 * o + 2;
    endfunction

    function automatic int lowest(input int v);
        for (int i = 0; i < 8; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic int next_above(input int v, input int c);
        for (int i = c + 1; i < 8; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    function automatic int oh(input int c);
        return (c < 0) ? 0 : (1 << c);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_cur = -1; m_rem = 0; m_chen = 0; m_osr = 0; m_fcnt = 0;
        e_data = 0; e_idx = 0; e_last = 0; e_fd = 0;
    endtask

    task automatic model_step();
        int nx;
        if (!bus.ENSAMP_sync) begin
            m_cur = -1; m_mode = 0; m_rem = 0;
            e_data = 0; e_idx = 0; e_last = 0; e_fd = 0;
        end else begin
            e_data = oh(m_cur);
            e_idx  = (m_cur < 0) ? 0 : m_cur;
            e_last = (m_cur >= 0 && next_above(m_chen, m_cur) < 0) ? 1 : 0;
            e_fd   = 0;
            if (m_mode == 0) begin
                if (bus.CHEN_sync != 0) begin
                    m_chen = int'(bus.CHEN_sync);
                    m_osr  = int'(bus.OSR_sync);
                    m_cur  = lowest(m_chen);
                    m_rem  = clen(m_osr);
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_rem--;
                if (m_rem == 0) begin
                    nx = next_above(m_chen, m_cur);
                    if (nx >= 0) begin
                        m_cur = nx;
                        m_rem = clen(m_osr);
                    end else begin
                        e_fd = 1;
                        m_fcnt = (m_fcnt + 1) % 256;
                        if (bus.ONESHOT_sync) begin
                            m_cur = -1;
                            m_mode = 2;
                        end else begin
                            m_chen = int'(bus.CHEN_sync);
                            m_osr  = int'(bus.OSR_sync);
                            m_cur  = lowest(m_chen);
                            m_rem  = clen(m_osr);
                            if (m_cur < 0) m_mode = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".ATMCHSEL"},   int'(bus.ATMCHSEL), oh(m_cur));
        check({ph, ".DATA"},       int'(bus.ATMCHSEL_DATA), e_data);
        check({ph, ".CHIDX"},      int'(bus.CHIDX_DATA), e_idx);
        check({ph, ".LASTWORD"},   int'(bus.LASTWORD), e_last);
        check({ph, ".FRAME_DONE"}, int'(bus.FRAME_DONE), e_fd);
        check({ph, ".FRAME_CNT"},  int'(bus.FRAME_CNT), m_fcnt);
        check({ph, ".BUSY"},       int'(bus.BUSY), (m_mode == 1) ? 1 : 0);
        check({ph, ".CHSEL"},      int'(bus.CHSEL), bus.ENLOWPWR_sync ? oh(m_cur) : int'(bus.CHEN_sync));
    endtask

    task automatic run(input string ph, input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
            compare_all(ph);
        end
    endtask

    task automatic set_in(input bit en, input int chen, input int osr, input bit os, input bit lp);
        bus.ENSAMP_sync   = en;
        bus.CHEN_sync     = 8'(chen);
        bus.OSR_sync      = 4'(osr);
        bus.ONESHOT_sync  = os;
        bus.ENLOWPWR_sync = lp;
    endtask

    task automatic async_reset(input string ph);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(ph);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 1);
        model_reset();
        #1;
        compare_all("reset");
        #11;
        rst_n = 1'b1;
        run("idle", 2);

        set_in(1, 8'h05, 0, 0, 1);
        run("t1_osr0", 12);
        set_in(0, 8'h05, 0, 0, 1);
        run("t1_stop", 2);

        set_in(1, 8'h81, 2, 0, 1);
        run("t2_81", 45);
        set_in(0, 0, 0, 0, 1);
        run("t2_stop", 2);

        set_in(1, 8'h0E, 1, 1, 1);
        run("t3_oneshot", 24);
        set_in(1, 8'hFF, 0, 0, 1);
        run("t3_halt", 4);
        set_in(0, 8'hFF, 0, 0, 1);
        run("t3_drop", 2);

        set_in(1, 8'h0F, 1, 0, 0);
        run("t4_pre", 3);
        set_in(1, 8'h30, 2, 0, 0);
        run("t4_reconf", 50);
        set_in(0, 8'h30, 2, 0, 0);
        run("t4_stop", 1);

        set_in(1, 8'h00, 3, 0, 1);
        run("t5_empty", 4);
        set_in(1, 8'h40, 3, 0, 1);
        run("t5_single", 45);

        set_in(1, 8'h06, 2, 0, 1);
        run("t6_pre", 4);
        async_reset("t6_rst");
        run("t6_post", 12);
        set_in(0, 8'h06, 2, 0, 1);
        run("t6_drop", 3);

        set_in(1, 8'h01, 0, 0, 1);
        run("t6_wrap", 262);
        set_in(0, 8'h01, 0, 0, 1);
        run("t6_hold", 2);

        for (int s = 0; s < 60; s++) begin
            set_in($urandom_range(0, 9) != 0, int'($urandom_range(0, 255)) & ($urandom_range(0, 5) == 0 ? 0 : 255),
                   $urandom_range(0, 15) & ($urandom_range(0, 2) == 0 ? 15 : 3),
                   $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
            run("rand", int'($urandom_range(1, 30)));
            if (s % 20 == 10) async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
